// File: rtl/uart_pkg.sv
// Shared types and helpers for the runtime-configurable UART core.
package uart_pkg;

   localparam int unsigned OVRSAMPLING = 16;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
   } rx_state_t;

   function automatic logic [3:0] data_bit_count(input logic [1:0] cfg);
      return 4'(cfg) + 4'd5;
   endfunction

   function automatic logic [7:0] data_mask(input logic [1:0] cfg);
      return 8'hFF >> (2'd3 - cfg);
   endfunction

   // The reserved encoding 2'b11 behaves as no parity.
   function automatic parity_t decode_parity(input logic [1:0] cfg);
      return (cfg == 2'b11) ? PAR_NONE : parity_t'(cfg);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used for the TX and RX queues.
module uart_sync_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  wr_en;
   logic                  rd_en;

   // A full FIFO still accepts a write when a read frees a slot in the same cycle.
   assign wr_en   = wr && (!full || rd);
   assign rd_en   = rd && !empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (rd_en) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_cfg_core.sv
// UART core: baud tick generator, 16x-oversampled TX/RX engines and TX/RX FIFOs
// with runtime-selectable frame format.
module uart_cfg_core #(
   parameter int unsigned MAX_DATA_BITS   = 8,
   parameter int unsigned FIFO_ADDR_WIDTH = 4,
   parameter int unsigned OVRSAMPLING     = uart_pkg::OVRSAMPLING,
   parameter int unsigned DVSR_WIDTH      = 11
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DVSR_WIDTH-1:0]    dvsr,
   input  logic [1:0]               cfg_data_bits,
   input  logic [1:0]               cfg_parity,
   input  logic                     cfg_stop2,
   input  logic                     wr_uart,
   input  logic [MAX_DATA_BITS-1:0] wr_data,
   input  logic                     rd_uart,
   output logic [MAX_DATA_BITS-1:0] rd_data,
   output logic                     rd_par_err,
   output logic                     rd_frm_err,
   input  logic                     clr_ovr,
   input  logic                     rx,
   output logic                     tx,
   output logic                     tx_full,
   output logic                     tx_empty,
   output logic                     rx_full,
   output logic                     rx_empty,
   output logic                     tx_busy,
   output logic                     rx_ovr
);
   import uart_pkg::*;

   localparam int unsigned TICK_W = $clog2(2 * OVRSAMPLING);
   localparam int unsigned IDX_W  = $clog2(MAX_DATA_BITS);
   localparam int unsigned RXF_W  = MAX_DATA_BITS + 2;
   localparam logic [TICK_W-1:0] BIT_END      = TICK_W'(OVRSAMPLING - 1);
   localparam logic [TICK_W-1:0] STOP2_END    = TICK_W'(2 * OVRSAMPLING - 1);
   localparam logic [TICK_W-1:0] START_SAMPLE = TICK_W'(OVRSAMPLING / 2 - 1);

   // Baud tick generator
   logic [DVSR_WIDTH-1:0] baud_cnt;
   logic                  tick;

   assign tick = (baud_cnt == dvsr);

   always_ff @(posedge clk) begin
      if (reset) baud_cnt <= '0;
      else       baud_cnt <= tick ? '0 : baud_cnt + DVSR_WIDTH'(1);
   end

   // FIFOs
   logic                     tx_pop;
   logic [MAX_DATA_BITS-1:0] tx_head;
   logic                     rx_push;
   logic [RXF_W-1:0]         rx_wdata;
   logic [RXF_W-1:0]         rx_head;

   uart_sync_fifo #(.DATA_WIDTH(MAX_DATA_BITS), .ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .wr(wr_uart), .wr_data(wr_data), .rd(tx_pop),
      .rd_data(tx_head), .full(tx_full), .empty(tx_empty)
   );

   uart_sync_fifo #(.DATA_WIDTH(RXF_W), .ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .wr(rx_push), .wr_data(rx_wdata), .rd(rd_uart),
      .rd_data(rx_head), .full(rx_full), .empty(rx_empty)
   );

   assign rd_data    = rx_empty ? '0 : rx_head[MAX_DATA_BITS-1:0];
   assign rd_par_err = !rx_empty && rx_head[MAX_DATA_BITS];
   assign rd_frm_err = !rx_empty && rx_head[MAX_DATA_BITS+1];

   // TX engine
   tx_state_t                tx_state;
   logic [TICK_W-1:0]        tx_s;
   logic [IDX_W-1:0]         tx_n;
   logic [MAX_DATA_BITS-1:0] tx_sr;
   logic [3:0]               tx_nbits;
   parity_t                  tx_par;
   logic                     tx_stop2;
   logic                     tx_pbit;
   logic                     tx_stop_end;

   assign tx_stop_end = tick && (tx_s == (tx_stop2 ? STOP2_END : BIT_END));
   // The next frame loads straight out of STOP so back-to-back frames have no gap.
   assign tx_pop = !tx_empty &&
                   (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_stop_end));

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_s     <= '0;
         tx_n     <= '0;
         tx_sr    <= '0;
         tx_nbits <= 4'd8;
         tx_par   <= PAR_NONE;
         tx_stop2 <= 1'b0;
         tx_pbit  <= 1'b0;
      end else if (tx_pop) begin
         tx_state <= TX_START;
         tx       <= 1'b0;
         tx_busy  <= 1'b1;
         tx_s     <= '0;
         tx_sr    <= tx_head;
         tx_nbits <= data_bit_count(cfg_data_bits);
         tx_par   <= decode_parity(cfg_parity);
         tx_stop2 <= cfg_stop2;
         tx_pbit  <= (^(tx_head & data_mask(cfg_data_bits))) ^
                     (decode_parity(cfg_parity) == PAR_ODD);
      end else if (tick) begin
         case (tx_state)
            TX_IDLE: ;
            TX_START: begin
               if (tx_s == BIT_END) begin
                  tx_s     <= '0;
                  tx_n     <= '0;
                  tx       <= tx_sr[0];
                  tx_state <= TX_DATA;
               end else tx_s <= tx_s + TICK_W'(1);
            end
            TX_DATA: begin
               if (tx_s == BIT_END) begin
                  tx_s  <= '0;
                  tx_sr <= tx_sr >> 1;
                  if (4'(tx_n) + 4'd1 == tx_nbits) begin
                     tx       <= (tx_par == PAR_NONE) ? 1'b1 : tx_pbit;
                     tx_state <= (tx_par == PAR_NONE) ? TX_STOP : TX_PARITY;
                  end else begin
                     tx_n <= tx_n + IDX_W'(1);
                     tx   <= tx_sr[1];
                  end
               end else tx_s <= tx_s + TICK_W'(1);
            end
            TX_PARITY: begin
               if (tx_s == BIT_END) begin
                  tx_s     <= '0;
                  tx       <= 1'b1;
                  tx_state <= TX_STOP;
               end else tx_s <= tx_s + TICK_W'(1);
            end
            TX_STOP: begin
               if (tx_stop_end) begin
                  tx_state <= TX_IDLE;
                  tx_busy  <= 1'b0;
               end else tx_s <= tx_s + TICK_W'(1);
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // RX synchroniser plus one extra stage for falling-edge detection
   logic rx_q1, rx_s, rx_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_q1 <= 1'b1;
         rx_s  <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_q1 <= rx;
         rx_s  <= rx_q1;
         rx_d  <= rx_s;
      end
   end

   // RX engine
   rx_state_t                rx_state;
   logic [TICK_W-1:0]        rx_sc;
   logic [IDX_W-1:0]         rx_n;
   logic [MAX_DATA_BITS-1:0] rx_dat;
   logic [3:0]               rx_nbits;
   parity_t                  rx_par;
   logic                     rx_perr;

   assign rx_push  = (rx_state == RX_STOP) && tick && (rx_sc == BIT_END);
   assign rx_wdata = {!rx_s, rx_perr, rx_dat};

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         rx_sc    <= '0;
         rx_n     <= '0;
         rx_dat   <= '0;
         rx_nbits <= 4'd8;
         rx_par   <= PAR_NONE;
         rx_perr  <= 1'b0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (rx_d && !rx_s) begin
                  rx_state <= RX_START;
                  rx_sc    <= '0;
                  rx_dat   <= '0;
                  rx_perr  <= 1'b0;
                  rx_nbits <= data_bit_count(cfg_data_bits);
                  rx_par   <= decode_parity(cfg_parity);
               end
            end
            RX_START: begin
               if (tick) begin
                  if (rx_sc == START_SAMPLE) begin
                     rx_sc    <= '0;
                     rx_n     <= '0;
                     rx_state <= rx_s ? RX_IDLE : RX_DATA;
                  end else rx_sc <= rx_sc + TICK_W'(1);
               end
            end
            RX_DATA: begin
               if (tick) begin
                  if (rx_sc == BIT_END) begin
                     rx_sc        <= '0;
                     rx_dat[rx_n] <= rx_s;
                     if (4'(rx_n) + 4'd1 == rx_nbits)
                        rx_state <= (rx_par == PAR_NONE) ? RX_STOP : RX_PARITY;
                     else
                        rx_n <= rx_n + IDX_W'(1);
                  end else rx_sc <= rx_sc + TICK_W'(1);
               end
            end
            RX_PARITY: begin
               if (tick) begin
                  if (rx_sc == BIT_END) begin
                     rx_sc    <= '0;
                     rx_perr  <= rx_s ^ (^rx_dat) ^ (rx_par == PAR_ODD);
                     rx_state <= RX_STOP;
                  end else rx_sc <= rx_sc + TICK_W'(1);
               end
            end
            RX_STOP: begin
               if (tick) begin
                  if (rx_sc == BIT_END) rx_state <= RX_IDLE;
                  else                  rx_sc    <= rx_sc + TICK_W'(1);
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // Sticky overrun; a new overrun outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset)                                rx_ovr <= 1'b0;
      else if (rx_push && rx_full && !rd_uart)  rx_ovr <= 1'b1;
      else if (clr_ovr)                         rx_ovr <= 1'b0;
   end

endmodule

// File: tb/tb_uart_cfg_core.sv
// Directed self-checking bench for uart_cfg_core (4-deep FIFOs, dvsr=3).
module tb_uart_cfg_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] dvsr;
   logic [1:0]  cfg_data_bits;
   logic [1:0]  cfg_parity;
   logic        cfg_stop2;
   logic        wr_uart;
   logic [7:0]  wr_data;
   logic        rd_uart;
   logic [7:0]  rd_data;
   logic        rd_par_err;
   logic        rd_frm_err;
   logic        clr_ovr;
   logic        rx;
   logic        tx;
   logic        tx_full, tx_empty, rx_full, rx_empty;
   logic        tx_busy;
   logic        rx_ovr;

   logic        loop;
   logic        rx_drv;
   assign rx = loop ? tx : rx_drv;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rc       = 0;

   logic [11:0] bits;
   logic [11:0] fbits;
   int          low_len;
   bit          found;

   uart_cfg_core #(
      .MAX_DATA_BITS(8), .FIFO_ADDR_WIDTH(2), .OVRSAMPLING(16), .DVSR_WIDTH(11)
   ) dut (
      .clk(clk), .reset(reset), .dvsr(dvsr), .cfg_data_bits(cfg_data_bits),
      .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .wr_uart(wr_uart),
      .wr_data(wr_data), .rd_uart(rd_uart), .rd_data(rd_data),
      .rd_par_err(rd_par_err), .rd_frm_err(rd_frm_err), .clr_ovr(clr_ovr),
      .rx(rx), .tx(tx), .tx_full(tx_full), .tx_empty(tx_empty),
      .rx_full(rx_full), .rx_empty(rx_empty), .tx_busy(tx_busy), .rx_ovr(rx_ovr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_uart = 1'b1;
      wr_data = b;
      step(1);
      wr_uart = 1'b0;
   endtask

   task automatic pop;
      rd_uart = 1'b1;
      step(1);
      rd_uart = 1'b0;
   endtask

   task automatic wait_fall(input int limit, output bit f);
      f = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (tx === 1'b0) begin
            f = 1'b1;
            break;
         end
         step(1);
      end
   endtask

   // Samples every bit of a TX frame at its centre; also measures the start-bit length.
   task automatic tx_frame(input int nb, output logic [11:0] b, output int ll);
      bit f;
      b  = '0;
      ll = 0;
      wait_fall(3000, f);
      chk("tx_frame_start", 32'(f), 32'd1);
      if (f) begin
         for (int o = 0; o <= 32 + 64 * (nb - 1); o++) begin
            if (o > 0) step(1);
            if (tx === 1'b1 && ll == 0) ll = o;
            if (o % 64 == 32) b[o / 64] = tx;
         end
      end
   endtask

   task automatic wait_rx(input string tag);
      bit f = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!rx_empty) begin
            f = 1'b1;
            break;
         end
         step(1);
      end
      chk(tag, 32'(f), 32'd1);
   endtask

   task automatic drive_rx(input logic [11:0] b, input int nb);
      for (int i = 0; i < nb; i++) begin
         rx_drv = b[i];
         step(64);
      end
   endtask

   initial begin
      reset = 1'b1; dvsr = 11'd3; cfg_data_bits = 2'd3; cfg_parity = 2'd0;
      cfg_stop2 = 1'b0; wr_uart = 1'b0; wr_data = 8'h00; rd_uart = 1'b0;
      clr_ovr = 1'b0; loop = 1'b0; rx_drv = 1'b1;
      step(3);
      reset = 1'b0;
      rc = cyc;

      // Reset state: {tx,tx_busy,rx_ovr,tx_empty,rx_empty,tx_full,rx_full}
      chk("reset_flags", 32'({tx, tx_busy, rx_ovr, tx_empty, rx_empty, tx_full, rx_full}),
          32'(7'b1001100));
      chk("reset_rd", 32'({rd_par_err, rd_frm_err, rd_data}), 32'd0);

      // 8N1 loopback 0xA5, write timed so the start bit spans exactly 16 ticks
      loop = 1'b1;
      while ((cyc - rc) % 4 != 2) step(1);
      write_byte(8'hA5);
      tx_frame(10, bits, low_len);
      chk("a5_start_len", 32'(low_len), 32'd64);
      chk("a5_tx_bits", 32'(bits[9:0]), 32'(10'b1_1010_0101_0));
      wait_rx("a5_rx_arrive");
      chk("a5_rd", 32'({rd_frm_err, rd_par_err, rd_data}), 32'h0A5);
      pop;
      chk("a5_popped", 32'(rx_empty), 32'd1);
      step(64);

      // 7E1 loopback 0x35: four ones, so even parity bit is 0
      cfg_data_bits = 2'd2; cfg_parity = 2'd1;
      write_byte(8'h35);
      tx_frame(10, bits, low_len);
      chk("7e1_tx_bits", 32'(bits[9:0]), 32'(10'b1_0_0110101_0));
      wait_rx("7e1_rx_arrive");
      chk("7e1_rd", 32'({rd_frm_err, rd_par_err, rd_data}), 32'h035);
      pop;
      step(64);

      // 7O1 loopback 0x35: parity bit 1
      cfg_parity = 2'd2;
      write_byte(8'h35);
      tx_frame(10, bits, low_len);
      chk("7o1_tx_bits", 32'(bits[9:0]), 32'(10'b1_1_0110101_0));
      wait_rx("7o1_rx_arrive");
      chk("7o1_rd", 32'({rd_frm_err, rd_par_err, rd_data}), 32'h035);
      pop;
      step(64);

      // External 7E1 frame 0x35 with the parity bit flipped
      rx_drv = 1'b1; loop = 1'b0;
      cfg_parity = 2'd1;
      fbits = {2'b00, 1'b1, 1'b1, 7'h35, 1'b0};
      drive_rx(fbits, 10);
      wait_rx("perr_rx_arrive");
      chk("perr_rd", 32'({rd_frm_err, rd_par_err, rd_data}), 32'h135);
      pop;

      // External 8N1 frame 0x3C with stop bit 0
      cfg_data_bits = 2'd3; cfg_parity = 2'd0;
      fbits = {2'b00, 1'b0, 8'h3C, 1'b0};
      drive_rx(fbits, 10);
      rx_drv = 1'b1;
      wait_rx("ferr_rx_arrive");
      chk("ferr_rd", 32'({rd_frm_err, rd_par_err, rd_data}), 32'h23C);
      pop;
      step(64);

      // Glitch of 4 ticks is rejected
      rx_drv = 1'b0;
      step(16);
      rx_drv = 1'b1;
      step(1000);
      chk("glitch_no_push", 32'(rx_empty), 32'd1);

      // Five loopback frames into a 4-deep RX FIFO
      loop = 1'b1;
      wr_uart = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_data = 8'(i + 1);
         step(1);
      end
      wr_uart = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         if (rx_ovr) begin
            found = 1'b1;
            break;
         end
         step(1);
      end
      chk("ovr_set", 32'(found), 32'd1);
      chk("ovr_rx_full", 32'(rx_full), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("ovr_rd_order", 32'(rd_data), 32'(i + 1));
         pop;
      end
      chk("ovr_drained", 32'(rx_empty), 32'd1);
      chk("ovr_sticky", 32'(rx_ovr), 32'd1);
      clr_ovr = 1'b1;
      step(1);
      clr_ovr = 1'b0;
      chk("ovr_cleared", 32'(rx_ovr), 32'd0);
      step(64);

      // Six back-to-back writes: five frames go out, the sixth is lost
      wr_uart = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_data = 8'(8'h11 * (i + 1));
         step(1);
      end
      wr_uart = 1'b0;
      chk("b2b_tx_full", 32'(tx_full), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tx_frame(10, bits, low_len);
         chk("b2b_frame_data", 32'(bits[8:1]), 32'(8'h11 * (i + 1)));
      end
      wait_fall(1000, found);
      chk("b2b_no_sixth", 32'(found), 32'd0);
      chk("b2b_idle", 32'({tx_busy, tx_empty}), 32'(2'b01));

      // Reset mid-DATA: RX still holds data and rx_ovr from the loopback above
      loop = 1'b0;
      write_byte(8'h5A);
      write_byte(8'h77);
      write_byte(8'h88);
      step(200);
      chk("pre_reset_state", 32'({tx_busy, tx_empty, rx_empty, rx_ovr}), 32'(4'b1001));
      reset = 1'b1;
      step(1);
      chk("mid_reset_flags", 32'({tx, tx_busy, rx_ovr, tx_empty, rx_empty, tx_full, rx_full}),
          32'(7'b1001100));
      chk("mid_reset_rd", 32'({rd_par_err, rd_frm_err, rd_data}), 32'd0);
      reset = 1'b0;
      step(200);
      chk("post_reset_quiet", 32'({tx, tx_busy}), 32'(2'b10));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
